clause_slot_alloc: RTL and testbench

Parametrised successor to the fixed 8-clause array's learnt-clause insertion logic. Tracks per-slot length and valid state for NUM_CLAUSES clause slots, split into an original region and a learnt region. Allocates a slot for each new learnt clause with a sequential scan: the first free learnt slot wins; otherwise the longest unlocked learnt clause is replaced. Sits beside the clause array and drives its one-hot write enables during add-learnt operations.

---
 rtl/clause_slot_alloc.sv | 193 +++++++++++++++++++
 tb/tb_clause_slot_alloc.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/clause_slot_alloc.sv
// Learnt-clause slot allocator: keeps per-slot length/valid state and picks
// a slot for each new learnt clause (first free learnt slot, else the longest
// unlocked learnt clause), driving one-hot write enables for the clause array.
module clause_slot_alloc #(
  parameter int unsigned NUM_CLAUSES = 16,
  parameter int unsigned NUM_ORIGIN  = 8,
  parameter int unsigned WIDTH_C_LEN = 4,
  parameter int unsigned WIDTH_IDX   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CLAUSES-1:0]             load_wr_i,
  input  logic [WIDTH_C_LEN-1:0]             clause_len_i,
  input  logic                               clear_learnt_i,
  input  logic                               learnt_req_i,
  input  logic [WIDTH_C_LEN-1:0]             learnt_len_i,
  input  logic [NUM_CLAUSES-1:0]             lock_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               fail_o,
  output logic                               replaced_o,
  output logic [NUM_CLAUSES-1:0]             learnt_wr_o,
  output logic [WIDTH_IDX-1:0]               learnt_idx_o,
  output logic [NUM_CLAUSES-1:0]             slot_valid_o,
  output logic [NUM_CLAUSES*WIDTH_C_LEN-1:0] clause_len_o,
  output logic [WIDTH_IDX:0]                 learnt_count_o
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT, S_FAIL} state_t;

  localparam logic [WIDTH_IDX-1:0] FIRST_LEARNT = WIDTH_IDX'(NUM_ORIGIN);
  localparam logic [WIDTH_IDX-1:0] LAST_SLOT    = WIDTH_IDX'(NUM_CLAUSES - 1);

  state_t                                    state_q, state_d;
  logic [NUM_CLAUSES-1:0]                    valid_q, valid_d;
  logic [NUM_CLAUSES-1:0][WIDTH_C_LEN-1:0]   len_q, len_d;
  logic [WIDTH_C_LEN-1:0]                    cap_len_q, cap_len_d;
  logic [WIDTH_IDX-1:0]                      p_q, p_d;
  logic [WIDTH_IDX-1:0]                      best_q, best_d;
  logic                                      best_valid_q, best_valid_d;
  logic                                      done_q, done_d;
  logic                                      fail_q, fail_d;
  logic                                      replaced_q, replaced_d;
  logic [NUM_CLAUSES-1:0]                    wr_q, wr_d;
  logic [WIDTH_IDX-1:0]                      idx_q, idx_d;
  logic [WIDTH_IDX:0]                        count_q, count_d;
  logic                                      do_commit;
  logic                                      do_replace;
  logic [WIDTH_IDX-1:0]                      sel;

  // Next-state: scan step, commit bookkeeping, loads, clear/abort, popcount.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    len_d        = len_q;
    cap_len_d    = cap_len_q;
    p_d          = p_q;
    best_d       = best_q;
    best_valid_d = best_valid_q;
    done_d       = 1'b0;
    fail_d       = 1'b0;
    replaced_d   = 1'b0;
    wr_d         = '0;
    idx_d        = idx_q;
    count_d      = '0;
    do_commit    = 1'b0;
    do_replace   = 1'b0;
    sel          = p_q;

    unique case (state_q)
      S_IDLE: begin
        if (learnt_req_i) begin
          cap_len_d    = learnt_len_i;
          p_d          = FIRST_LEARNT;
          best_valid_d = 1'b0;
          state_d      = S_SCAN;
        end
      end
      S_SCAN: begin
        if (!valid_q[p_q]) begin
          do_commit = 1'b1;
          sel       = p_q;
        end else begin
          // Strict '>' keeps the lower index on equal lengths.
          if (!lock_i[p_q] && (!best_valid_q || (len_q[p_q] > len_q[best_q]))) begin
            best_d       = p_q;
            best_valid_d = 1'b1;
          end
          if (p_q == LAST_SLOT) begin
            if (best_valid_d) begin
              do_commit  = 1'b1;
              do_replace = 1'b1;
              sel        = best_d;
            end else begin
              state_d = S_FAIL;
              done_d  = 1'b1;
              fail_d  = 1'b1;
            end
          end else begin
            p_d = p_q + 1'b1;
          end
        end
      end
      S_COMMIT: state_d = S_IDLE;
      S_FAIL:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Slot state is updated on entry to COMMIT so slot_valid_o and
    // learnt_count_o already include the new clause while done_o is high.
    if (do_commit) begin
      state_d      = S_COMMIT;
      done_d       = 1'b1;
      replaced_d   = do_replace;
      idx_d        = sel;
      valid_d[sel] = 1'b1;
      len_d[sel]   = cap_len_q;
      for (int unsigned i = 0; i < NUM_CLAUSES; i++)
        wr_d[i] = (sel == WIDTH_IDX'(i));
    end

    if (state_q == S_IDLE) begin
      for (int unsigned i = 0; i < NUM_CLAUSES; i++) begin
        if (load_wr_i[i]) begin
          len_d[i]   = clause_len_i;
          valid_d[i] = |clause_len_i;
        end
      end
    end

    if (clear_learnt_i) begin
      for (int unsigned i = NUM_ORIGIN; i < NUM_CLAUSES; i++) begin
        valid_d[i] = 1'b0;
        len_d[i]   = '0;
      end
      if (state_q != S_IDLE) begin
        state_d    = S_IDLE;
        done_d     = 1'b0;
        fail_d     = 1'b0;
        replaced_d = 1'b0;
        wr_d       = '0;
        idx_d      = idx_q;
      end
    end

    for (int unsigned i = NUM_ORIGIN; i < NUM_CLAUSES; i++)
      count_d = count_d + {{WIDTH_IDX{1'b0}}, valid_d[i]};
  end

  // State and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      len_q        <= '0;
      cap_len_q    <= '0;
      p_q          <= '0;
      best_q       <= '0;
      best_valid_q <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      replaced_q   <= 1'b0;
      wr_q         <= '0;
      idx_q        <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      len_q        <= len_d;
      cap_len_q    <= cap_len_d;
      p_q          <= p_d;
      best_q       <= best_d;
      best_valid_q <= best_valid_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      replaced_q   <= replaced_d;
      wr_q         <= wr_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
    end
  end

  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = done_q;
  assign fail_o         = fail_q;
  assign replaced_o     = replaced_q;
  assign learnt_wr_o    = wr_q;
  assign learnt_idx_o   = idx_q;
  assign slot_valid_o   = valid_q;
  assign clause_len_o   = len_q;
  assign learnt_count_o = count_q;

endmodule

// File: tb/tb_clause_slot_alloc.sv
// Directed bench for clause_slot_alloc with hand-computed expectations.
module tb_clause_slot_alloc;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] load_wr_i;
  logic [3:0]  clause_len_i;
  logic        clear_learnt_i;
  logic        learnt_req_i;
  logic [3:0]  learnt_len_i;
  logic [15:0] lock_i;
  logic        busy_o, done_o, fail_o, replaced_o;
  logic [15:0] learnt_wr_o;
  logic [3:0]  learnt_idx_o;
  logic [15:0] slot_valid_o;
  logic [63:0] clause_len_o;
  logic [4:0]  learnt_count_o;

  int errors = 0;
  int checks = 0;
  int cyc;
  logic [63:0] len_snap;
  logic [15:0] valid_snap;
  logic        saw_done;
  logic [3:0]  fill_len [8];

  clause_slot_alloc #(
    .NUM_CLAUSES(16), .NUM_ORIGIN(8), .WIDTH_C_LEN(4), .WIDTH_IDX(4)
  ) dut (
    .clk(clk), .rst(rst), .load_wr_i(load_wr_i), .clause_len_i(clause_len_i),
    .clear_learnt_i(clear_learnt_i), .learnt_req_i(learnt_req_i),
    .learnt_len_i(learnt_len_i), .lock_i(lock_i), .busy_o(busy_o),
    .done_o(done_o), .fail_o(fail_o), .replaced_o(replaced_o),
    .learnt_wr_o(learnt_wr_o), .learnt_idx_o(learnt_idx_o),
    .slot_valid_o(slot_valid_o), .clause_len_o(clause_len_o),
    .learnt_count_o(learnt_count_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int slot, input logic [3:0] len);
    load_wr_i    = 16'h0001 << slot;
    clause_len_i = len;
    tick();
    load_wr_i    = '0;
  endtask

  // Cycle 0 is the cycle in which the request is presented.
  task automatic run_req(input logic [3:0] len, output int c);
    learnt_req_i = 1'b1;
    learnt_len_i = len;
    tick();
    learnt_req_i = 1'b0;
    c = 1;
    while (!done_o && c < 20) begin
      tick();
      c++;
    end
  endtask

  initial begin
    rst = 1'b0; load_wr_i = '0; clause_len_i = '0; clear_learnt_i = 1'b0;
    learnt_req_i = 1'b0; learnt_len_i = '0; lock_i = '0;
    fill_len[0] = 4'd2; fill_len[1] = 4'd7; fill_len[2] = 4'd4; fill_len[3] = 4'd7;
    fill_len[4] = 4'd1; fill_len[5] = 4'd3; fill_len[6] = 4'd5; fill_len[7] = 4'd6;
    tick(); tick();
    rst = 1'b1;
    tick();

    // Reset state
    chk("rst_busy",  busy_o, 0);
    chk("rst_done",  done_o, 0);
    chk("rst_valid", slot_valid_o, 0);
    chk("rst_len",   clause_len_o, 0);
    chk("rst_count", learnt_count_o, 0);
    chk("rst_idx",   learnt_idx_o, 0);

    // Load rules: length 0 deletes
    load(0, 4'd5);
    chk("load_valid0", slot_valid_o[0], 1);
    load(0, 4'd0);
    chk("del_valid0", slot_valid_o[0], 0);
    load(1, 4'd6);
    chk("load_len1", clause_len_o[7:4], 6);

    // Free slot: 8,9 occupied -> slot 10 at cycle 4
    load(8, 4'd3);
    load(9, 4'd3);
    chk("pre_count", learnt_count_o, 2);
    run_req(4'd5, cyc);
    chk("free_cyc",   cyc, 4);
    chk("free_done",  done_o, 1);
    chk("free_idx",   learnt_idx_o, 10);
    chk("free_wr",    learnt_wr_o, 16'h0400);
    chk("free_rep",   replaced_o, 0);
    chk("free_fail",  fail_o, 0);
    chk("free_count", learnt_count_o, 3);
    chk("free_len10", clause_len_o[43:40], 5);
    tick();
    chk("free_busy_fall", busy_o, 0);
    chk("free_done_fall", done_o, 0);
    chk("free_idx_hold",  learnt_idx_o, 10);

    // Replacement: full region, longest is slot 9 (tie with 11 keeps 9)
    clear_learnt_i = 1'b1;
    tick();
    clear_learnt_i = 1'b0;
    for (int i = 0; i < 8; i++) load(8 + i, fill_len[i]);
    chk("full_count", learnt_count_o, 8);
    run_req(4'd2, cyc);
    chk("rep_cyc",   cyc, 9);
    chk("rep_idx",   learnt_idx_o, 9);
    chk("rep_wr",    learnt_wr_o, 16'h0200);
    chk("rep_rep",   replaced_o, 1);
    chk("rep_len9",  clause_len_o[39:36], 2);
    chk("rep_count", learnt_count_o, 8);
    tick();

    // Lock skip: 9 and 11 locked -> slot 15 (len 6)
    load(9, 4'd7);
    lock_i = 16'h0A00;
    run_req(4'd3, cyc);
    chk("lock_idx",   learnt_idx_o, 15);
    chk("lock_rep",   replaced_o, 1);
    chk("lock_len15", clause_len_o[63:60], 3);
    chk("lock_len9",  clause_len_o[39:36], 7);
    tick();

    // All locked: fail, no state change
    lock_i     = 16'hFF00;
    len_snap   = clause_len_o;
    valid_snap = slot_valid_o;
    run_req(4'd4, cyc);
    chk("fail_cyc",  cyc, 9);
    chk("fail_fail", fail_o, 1);
    chk("fail_done", done_o, 1);
    chk("fail_wr",   learnt_wr_o, 0);
    chk("fail_rep",  replaced_o, 0);
    tick();
    chk("fail_len",   clause_len_o, len_snap);
    chk("fail_valid", slot_valid_o, valid_snap);
    chk("fail_busy",  busy_o, 0);
    lock_i = '0;

    // Load while busy ignored, then abort by clear at scan cycle 3
    saw_done     = 1'b0;
    learnt_req_i = 1'b1;
    learnt_len_i = 4'd1;
    tick();
    learnt_req_i = 1'b0;
    chk("scan_busy", busy_o, 1);
    load_wr_i    = 16'h0008;
    clause_len_i = 4'd9;
    tick();
    load_wr_i    = '0;
    saw_done     = saw_done | done_o;
    chk("busy_load_len3",   clause_len_o[15:12], 0);
    chk("busy_load_valid3", slot_valid_o[3], 0);
    tick();
    saw_done       = saw_done | done_o;
    clear_learnt_i = 1'b1;
    tick();
    clear_learnt_i = 1'b0;
    saw_done       = saw_done | done_o;
    chk("abort_busy",   busy_o, 0);
    chk("abort_count",  learnt_count_o, 0);
    chk("abort_learnt", slot_valid_o[15:8], 0);
    chk("abort_origin", slot_valid_o[7:0], 8'h02);
    tick();
    saw_done = saw_done | done_o;
    chk("abort_nodone", saw_done, 0);

    // Reset mid-scan
    for (int i = 0; i < 8; i++) load(8 + i, 4'd1);
    learnt_req_i = 1'b1;
    learnt_len_i = 4'd2;
    tick();
    learnt_req_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("mrst_busy",  busy_o, 0);
    chk("mrst_done",  done_o, 0);
    chk("mrst_fail",  fail_o, 0);
    chk("mrst_wr",    learnt_wr_o, 0);
    chk("mrst_idx",   learnt_idx_o, 0);
    chk("mrst_valid", slot_valid_o, 0);
    chk("mrst_len",   clause_len_o, 0);
    chk("mrst_count", learnt_count_o, 0);
    rst = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
